chunked_adder_seq: RTL and testbench
====================================

// Module: chunked_adder_seq
// PURPOSE
//  Parametrised multi-cycle adder/subtractor. Computes a +/- b over WIDTH bits using
//  one CHUNK-bit ripple slice, reused for NCHUNK = WIDTH/CHUNK cycles. Trades latency
//  for area versus the flat ripple adder. Used in datapaths where the operand width
//  exceeds one slice. Uses valid/ready handshakes on input and output.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK  4   bits processed per cycle (slice width); 1 <= CHUNK <= WIDTH
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands present on a/b/carry_in/sub
//  in_ready   out  1      block can accept operands (IDLE only)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  carry_in   in   1      carry into bit 0 (add mode only)
//  sub        in   1      0: a+b+carry_in; 1: a-b (a + ~b + 1, carry_in ignored)
//  out_valid  out  1      result valid, held until accepted
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  carry_out  out  1      carry out of MSB (sub: 1 = no borrow)
//  overflow   out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, chunk index 0, in_ready=1,
//    out_valid=0, sum=0, carry_out=0, overflow=0. Reset mid-RUN/DONE aborts; result lost.
//  - FSM: IDLE -> RUN on in_valid&&in_ready (edge E0: latch a, b or ~b, initial carry
//    = sub ? 1 : carry_in; idx=0). RUN: each edge adds chunk idx of A/B with running
//    carry and writes sum[idx*CHUNK +: CHUNK]; idx++. On the edge processing
//    idx=NCHUNK-1: latch carry_out, overflow; -> DONE. DONE: out_valid=1;
//    on out_valid&&out_ready -> IDLE.
//  - Latency: out_valid is high after edge E0+NCHUNK (NCHUNK=1: one cycle after accept).
//    Throughput: one operation per NCHUNK+2 cycles minimum (accept, RUN, DONE).
//  - in_ready=1 only in IDLE; in_valid outside IDLE is ignored, no operand capture.
//  - sum/carry_out/overflow stay stable while out_valid=1 and out_ready=0.
//    They are not cleared on return to IDLE. sum is partially updated during RUN;
//    consumers sample it only under out_valid.
//  - Arithmetic modulo 2^WIDTH; overflow uses carry into bit WIDTH-1, taken from the
//    final chunk's internal carry.
//  - Input operands need not be held after acceptance.
//  - Elaboration-time error if WIDTH % CHUNK != 0.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//    Also a clog2-based index-width helper.
//  - One sub-module: adder_slice #(CHUNK). Combinational; a, b, cin -> sum, cout,
//    c_msb (carry into top bit). Instantiated once.
//  - Top holds the FSM, chunk index counter, operand shift or index mux,
//    carry register and result register.
// TESTING (WIDTH=16, CHUNK=4 unless noted)
//  - 0x00FF + 0x0001, cin=0 -> out_valid 4 cycles after accept; sum=0x0100, cout=0, ovf=0.
//  - 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
//  - 0x7FFF + 0x0000, cin=1 -> sum=0x8000, ovf=1.
//  - sub: 0x0005 - 0x0007 -> sum=0xFFFE, cout=0.
//  - sub: 0x0009 - 0x0002 -> sum=0x0007, cout=1.
//  - Backpressure: hold out_ready=0 for 5 cycles -> sum stable, in_ready=0, extra
//    in_valid ignored. After out_ready=1, in_ready=1 next cycle.
//  - rst_n low during RUN (idx=2) -> outputs 0 immediately, in_ready=1 after release.
//    Next op computes correctly.
//  - Exhaustive sweep at WIDTH=4, CHUNK=1 and CHUNK=4, all a, b, cin, sub.
//    Compare against a behavioural +/- reference model.

Source files
------------

// File: rtl/chunked_adder_seq_pkg.sv
// Shared definitions for the chunked multi-cycle adder/subtractor:
// FSM state encoding and a helper that sizes the chunk index counter.
package chunked_adder_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Index counter width; never narrower than one bit so NCHUNK=1 still elaborates.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chunked_adder_seq_adder_slice.sv
// Combinational CHUNK-bit ripple slice. Also exposes the carry into its top bit
// so the parent can form signed overflow on the final chunk.
module adder_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   always_comb begin
      logic [CHUNK:0] c;
      c     = '0;
      sum   = '0;
      c[0]  = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout  = c[CHUNK];
      c_msb = c[CHUNK-1];
   end

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice reused over WIDTH/CHUNK cycles,
// with valid/ready handshakes on both the operand and the result side.
module chunked_adder_seq
   import chunked_adder_seq_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = idx_width(NCHUNK);
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
      $error("chunked_adder_seq: CHUNK must lie in 1..WIDTH");
   end
   if (WIDTH % CHUNK != 0) begin : g_bad_width
      $error("chunked_adder_seq: WIDTH must be a multiple of CHUNK");
   end

   state_t            state_reg;
   logic [IW-1:0]     idx_reg;
   logic [WIDTH-1:0]  a_reg;
   logic [WIDTH-1:0]  b_reg;
   logic              carry_reg;
   logic [WIDTH-1:0]  sum_reg;
   logic              carry_out_reg;
   logic              overflow_reg;
   logic              in_ready_reg;
   logic              out_valid_reg;

   logic [CHUNK-1:0]  slice_sum;
   logic              slice_cout;
   logic              slice_cmsb;

   // b_reg already holds ~b in subtract mode, so the slice only ever adds.
   adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a     (a_reg[idx_reg*CHUNK +: CHUNK]),
      .b     (b_reg[idx_reg*CHUNK +: CHUNK]),
      .cin   (carry_reg),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_cmsb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         carry_reg     <= 1'b0;
         sum_reg       <= '0;
         carry_out_reg <= 1'b0;
         overflow_reg  <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  a_reg        <= a;
                  b_reg        <= sub ? ~b : b;
                  carry_reg    <= sub ? 1'b1 : carry_in;
                  idx_reg      <= '0;
                  state_reg    <= ST_RUN;
                  in_ready_reg <= 1'b0;
               end
            end
            ST_RUN: begin
               sum_reg[idx_reg*CHUNK +: CHUNK] <= slice_sum;
               carry_reg <= slice_cout;
               if (idx_reg == LAST_IDX) begin
                  carry_out_reg <= slice_cout;
                  overflow_reg  <= slice_cmsb ^ slice_cout;
                  idx_reg       <= '0;
                  state_reg     <= ST_DONE;
                  out_valid_reg <= 1'b1;
               end else begin
                  idx_reg <= idx_reg + IW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_reg     <= ST_IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign sum       = sum_reg;
   assign carry_out = carry_out_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Self-checking bench: directed and random ops on a 16/4 instance, plus an
// exhaustive 4-bit sweep on CHUNK=1 and CHUNK=4 instances, against an arithmetic model.
module tb_chunked_adder_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // 16-bit, 4-bit chunk instance
   logic        iv16 = 0, or16 = 0, cin16 = 0, sub16 = 0;
   logic [15:0] a16 = 0, b16 = 0;
   logic        ir16, ov16, co16, ovf16;
   logic [15:0] sum16;

   chunked_adder_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .carry_in(cin16), .sub(sub16),
      .out_valid(ov16), .out_ready(or16), .sum(sum16),
      .carry_out(co16), .overflow(ovf16)
   );

   // 4-bit instances sharing the operand bus
   logic        iv4 = 0, or4 = 1, cin4 = 0, sub4 = 0;
   logic [3:0]  a4 = 0, b4 = 0;
   logic        ir_c1, ov_c1, co_c1, ovf_c1;
   logic        ir_c4, ov_c4, co_c4, ovf_c4;
   logic [3:0]  sum_c1, sum_c4;

   chunked_adder_seq #(.WIDTH(4), .CHUNK(1)) u_w4c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir_c1),
      .a(a4), .b(b4), .carry_in(cin4), .sub(sub4),
      .out_valid(ov_c1), .out_ready(or4), .sum(sum_c1),
      .carry_out(co_c1), .overflow(ovf_c1)
   );

   chunked_adder_seq #(.WIDTH(4), .CHUNK(4)) u_w4c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir_c4),
      .a(a4), .b(b4), .carry_in(cin4), .sub(sub4),
      .out_valid(ov_c4), .out_ready(or4), .sum(sum_c4),
      .carry_out(co_c4), .overflow(ovf_c4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic; carry_out = unsigned carry (sub: no borrow),
   // overflow = signed result outside the representable range.
   function automatic void ref_calc(input int w, input int a, input int b, input bit cin,
                                    input bit sub, output int s, output bit co, output bit ov);
      longint m = longint'(1) << w;
      longint sa = (a >= m / 2) ? a - m : a;
      longint sb = (b >= m / 2) ? b - m : b;
      longint r, sr;
      if (sub) begin
         r  = longint'(a) - longint'(b);
         co = (a >= b);
         sr = sa - sb;
      end else begin
         r  = longint'(a) + longint'(b) + longint'(cin);
         co = (r >= m);
         sr = sa + sb + longint'(cin);
      end
      s  = int'(((r % m) + m) % m);
      ov = (sr < -(m / 2)) || (sr > m / 2 - 1);
   endfunction

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input int hold, input string tag);
      int lat, s;
      bit ec, eo;
      logic [17:0] exp_res;
      ref_calc(16, int'(a), int'(b), cin, sub, s, ec, eo);
      exp_res = {ec, eo, s[15:0]};
      @(negedge clk);
      check({tag, " in_ready idle"}, ir16, 1);
      a16 = a; b16 = b; cin16 = cin; sub16 = sub; iv16 = 1;
      @(posedge clk); #1;
      // operands need not be held after acceptance
      iv16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
      lat = 0;
      while (!ov16 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, lat, 4);
      check({tag, " result"}, {co16, ovf16, sum16}, exp_res);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         iv16 = 1; a16 = 16'($urandom); b16 = 16'($urandom);
         @(posedge clk); #1;
         check({tag, " held result"}, {co16, ovf16, sum16}, exp_res);
         check({tag, " held valid/ready"}, {ov16, ir16}, 2'b10);
      end
      @(negedge clk);
      iv16 = 0; or16 = 1;
      @(posedge clk); #1;
      or16 = 0;
      check({tag, " release valid/ready"}, {ov16, ir16}, 2'b01);
      $display("op16 %-12s a=%04h b=%04h cin=%0d sub=%0d -> sum=%04h cout=%0d ovf=%0d lat=%0d",
               tag, a, b, cin, sub, sum16, co16, ovf16, lat);
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub);
      int s;
      bit ec, eo, got1, got4;
      logic [5:0] exp_res;
      ref_calc(4, int'(a), int'(b), cin, sub, s, ec, eo);
      exp_res = {ec, eo, s[3:0]};
      got1 = 0; got4 = 0;
      @(negedge clk);
      a4 = a; b4 = b; cin4 = cin; sub4 = sub; iv4 = 1;
      @(posedge clk); #1;
      iv4 = 0;
      for (int k = 0; k < 12 && !(got1 && got4); k++) begin
         if (ov_c4 && !got4) begin
            check("w4c4 result", {co_c4, ovf_c4, sum_c4}, exp_res);
            got4 = 1;
         end
         if (ov_c1 && !got1) begin
            check("w4c1 result", {co_c1, ovf_c1, sum_c1}, exp_res);
            got1 = 1;
         end
         if (!(got1 && got4)) begin
            @(posedge clk); #1;
         end
      end
      check("w4 results seen", {got1, got4}, 2'b11);
      for (int k = 0; k < 8 && !(ir_c1 && ir_c4); k++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset sum", sum16, 16'h0000);
      check("reset cout/ovf", {co16, ovf16}, 2'b00);
      check("reset valid/ready", {ov16, ir16}, 2'b01);
      @(negedge clk);
      rst_n = 1;

      // directed cases
      op16(16'h00FF, 16'h0001, 0, 0, 0, "00FF+1");
      op16(16'hFFFF, 16'h0001, 0, 0, 0, "FFFF+1");
      op16(16'h7FFF, 16'h0000, 1, 0, 0, "7FFF+0+c");
      op16(16'h0005, 16'h0007, 0, 1, 0, "5-7");
      op16(16'h0009, 16'h0002, 1, 1, 0, "9-2");
      op16(16'h8000, 16'h0001, 0, 1, 0, "8000-1");
      op16(16'hA5A5, 16'h5A5A, 0, 0, 5, "backpress");

      // reset while running at idx=2
      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h1111; cin16 = 0; sub16 = 0; iv16 = 1;
      @(posedge clk); #1;
      iv16 = 0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      check("midrun reset sum", sum16, 16'h0000);
      check("midrun reset cout/ovf", {co16, ovf16}, 2'b00);
      check("midrun reset valid/ready", {ov16, ir16}, 2'b01);
      @(negedge clk);
      rst_n = 1;
      op16(16'h1234, 16'h1111, 0, 0, 0, "post-reset");

      // random ops with random backpressure
      for (int i = 0; i < 40; i++) begin
         op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), "random");
      end

      // exhaustive 4-bit sweep on both chunk sizes
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               for (int is = 0; is < 2; is++) begin
                  op4(4'(ia), 4'(ib), 1'(ic), 1'(is));
               end
            end
         end
         $display("sweep4 a=%0h done (64 ops)", ia);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
